// File: rtl/sampletest_multi.sv
// Multi-lane sample test: one triangle vs LANES sample points per packet, stallable pipeline.
// Optional hit statistics counter enabled by defining SAMPLETEST_HIT_STATS_EN.
module sampletest_multi #(
    parameter int unsigned SIGFIG     = 24,
    parameter int unsigned RADIX      = 10,
    parameter int unsigned AXIS       = 3,
    parameter int unsigned COLORS     = 3,
    parameter int unsigned LANES      = 4,
    parameter int unsigned PIPE_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3*AXIS*SIGFIG-1:0]      tri_in,
    input  logic [COLORS*SIGFIG-1:0]      color_in,
    input  logic [LANES*2*SIGFIG-1:0]     sample_in,
    input  logic [LANES-1:0]              lane_en_in,
    input  logic                          cull_back_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES-1:0]              hit_mask_out,
    output logic [LANES*2*SIGFIG-1:0]     hit_xy_out,
    output logic [SIGFIG-1:0]             hit_z_out,
    output logic [COLORS*SIGFIG-1:0]      color_out
`ifdef SAMPLETEST_HIT_STATS_EN
    ,
    output logic [31:0]                   hit_cnt_out
`endif
);

    localparam int unsigned SW = LANES * 2 * SIGFIG;
    localparam int unsigned CW = COLORS * SIGFIG;
    localparam int unsigned HW = LANES * 6 * SIGFIG;
    localparam int unsigned PW = 2 * SIGFIG;
    localparam int unsigned DW = PW + 1;
    localparam int unsigned ML = (PIPE_DEPTH > 1) ? PIPE_DEPTH - 1 : 1;

    if (RADIX >= SIGFIG || AXIS < 3 || LANES < 1 || LANES > 16 || PIPE_DEPTH < 1) begin : g_bad_cfg
        $error("sampletest_multi: unsupported parameter set");
    end

    // Only x/y of all vertices and z of vertex 0 are consumed.
    logic tri_unused;
    assign tri_unused = ^tri_in;

    logic stall_c;
    assign stall_c  = out_valid && !out_ready;
    assign in_ready = !stall_c;

    // Vertices translated into each lane's sample frame: lane, vertex, axis.
    logic [HW-1:0] shift_c;
    always_comb begin
        shift_c = '0;
        for (int l = 0; l < LANES; l++)
            for (int v = 0; v < 3; v++)
                for (int a = 0; a < 2; a++)
                    shift_c[((l*3+v)*2+a)*SIGFIG +: SIGFIG] =
                        tri_in[(v*AXIS+a)*SIGFIG +: SIGFIG] - sample_in[(l*2+a)*SIGFIG +: SIGFIG];
    end

    function automatic logic [LANES-1:0] calc_mask(input logic [HW-1:0] sh,
                                                   input logic [LANES-1:0] en,
                                                   input logic cull);
        logic signed [SIGFIG-1:0] x [3];
        logic signed [SIGFIG-1:0] y [3];
        logic signed [PW-1:0]     pa;
        logic signed [PW-1:0]     pb;
        logic signed [DW-1:0]     d [3];
        logic [2:0]               neg;
        logic [2:0]               zero;
        logic                     front;
        logic                     back;
        int                       nx;
        calc_mask = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int v = 0; v < 3; v++) begin
                x[v] = $signed(sh[((l*3+v)*2)*SIGFIG +: SIGFIG]);
                y[v] = $signed(sh[((l*3+v)*2+1)*SIGFIG +: SIGFIG]);
            end
            for (int e = 0; e < 3; e++) begin
                nx      = (e == 2) ? 0 : e + 1;
                pa      = PW'(x[e]) * PW'(y[nx]);
                pb      = PW'(x[nx]) * PW'(y[e]);
                d[e]    = DW'(pa) - DW'(pb);
                neg[e]  = d[e][DW-1];
                zero[e] = (d[e] == '0);
            end
            // e1 uses a strict test so shared edges resolve to exactly one triangle.
            front = (neg[0] || zero[0]) && neg[1] && (neg[2] || zero[2]);
            back  = !neg[0] && !neg[1] && !zero[1] && !neg[2];
            calc_mask[l] = en[l] && (front || (!cull && back));
        end
    endfunction

    logic              head_valid;
    logic [LANES-1:0]  head_mask;
    logic [SW-1:0]     head_xy;
    logic [SIGFIG-1:0] head_z;
    logic [CW-1:0]     head_color;

    if (PIPE_DEPTH > 1) begin : g_shift_stage
        logic              s1_valid;
        logic [HW-1:0]     s1_shift;
        logic [LANES-1:0]  s1_en;
        logic              s1_cull;
        logic [SW-1:0]     s1_xy;
        logic [SIGFIG-1:0] s1_z;
        logic [CW-1:0]     s1_color;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1_valid <= 1'b0;
                s1_shift <= '0;
                s1_en    <= '0;
                s1_cull  <= 1'b0;
                s1_xy    <= '0;
                s1_z     <= '0;
                s1_color <= '0;
            end else if (!stall_c) begin
                s1_valid <= in_valid;
                s1_shift <= shift_c;
                s1_en    <= lane_en_in;
                s1_cull  <= cull_back_in;
                s1_xy    <= sample_in;
                s1_z     <= tri_in[2*SIGFIG +: SIGFIG];
                s1_color <= color_in;
            end
        end

        always_comb begin
            head_valid = s1_valid;
            head_mask  = calc_mask(s1_shift, s1_en, s1_cull);
            head_xy    = s1_xy;
            head_z     = s1_z;
            head_color = s1_color;
        end
    end else begin : g_direct
        always_comb begin
            head_valid = in_valid;
            head_mask  = calc_mask(shift_c, lane_en_in, cull_back_in);
            head_xy    = sample_in;
            head_z     = tri_in[2*SIGFIG +: SIGFIG];
            head_color = color_in;
        end
    end

    // Result delay line; the last entry drives the outputs.
    logic              m_valid [ML];
    logic [LANES-1:0]  m_mask  [ML];
    logic [SW-1:0]     m_xy    [ML];
    logic [SIGFIG-1:0] m_z     [ML];
    logic [CW-1:0]     m_color [ML];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < ML; k++) begin
                m_valid[k] <= 1'b0;
                m_mask[k]  <= '0;
                m_xy[k]    <= '0;
                m_z[k]     <= '0;
                m_color[k] <= '0;
            end
        end else if (!stall_c) begin
            m_valid[0] <= head_valid;
            m_mask[0]  <= head_mask;
            m_xy[0]    <= head_xy;
            m_z[0]     <= head_z;
            m_color[0] <= head_color;
            for (int k = 1; k < ML; k++) begin
                m_valid[k] <= m_valid[k-1];
                m_mask[k]  <= m_mask[k-1];
                m_xy[k]    <= m_xy[k-1];
                m_z[k]     <= m_z[k-1];
                m_color[k] <= m_color[k-1];
            end
        end
    end

    assign out_valid    = m_valid[ML-1];
    assign hit_mask_out = m_mask[ML-1];
    assign hit_xy_out   = m_xy[ML-1];
    assign hit_z_out    = m_z[ML-1];
    assign color_out    = m_color[ML-1];

`ifdef SAMPLETEST_HIT_STATS_EN
    // Saturating count of hits delivered downstream.
    logic [32:0] cnt_sum_c;
    assign cnt_sum_c = {1'b0, hit_cnt_out} + 33'($countones(hit_mask_out));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            hit_cnt_out <= '0;
        else if (out_valid && out_ready)
            hit_cnt_out <= cnt_sum_c[32] ? '1 : cnt_sum_c[31:0];
    end
`endif

endmodule

// File: tb/tb_sampletest_multi.sv
// Self-checking bench for sampletest_multi: directed edge cases, stall, reset, randomized traffic.
module tb_sampletest_multi;

    localparam int unsigned SIGFIG     = 24;
    localparam int unsigned RADIX      = 10;
    localparam int unsigned AXIS       = 3;
    localparam int unsigned COLORS     = 3;
    localparam int unsigned LANES      = 4;
    localparam int unsigned PIPE_DEPTH = 2;
    localparam int unsigned VW = 3 * AXIS * SIGFIG;
    localparam int unsigned SW = LANES * 2 * SIGFIG;
    localparam int unsigned CW = COLORS * SIGFIG;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [VW-1:0]     tri_in;
    logic [CW-1:0]     color_in;
    logic [SW-1:0]     sample_in;
    logic [LANES-1:0]  lane_en_in;
    logic              cull_back_in;
    logic              out_valid;
    logic              out_ready;
    logic [LANES-1:0]  hit_mask_out;
    logic [SW-1:0]     hit_xy_out;
    logic [SIGFIG-1:0] hit_z_out;
    logic [CW-1:0]     color_out;
`ifdef SAMPLETEST_HIT_STATS_EN
    logic [31:0]       hit_cnt_out;
    longint            exp_cnt;
`endif

    sampletest_multi #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .AXIS(AXIS), .COLORS(COLORS),
        .LANES(LANES), .PIPE_DEPTH(PIPE_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .tri_in(tri_in), .color_in(color_in), .sample_in(sample_in),
        .lane_en_in(lane_en_in), .cull_back_in(cull_back_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .hit_mask_out(hit_mask_out), .hit_xy_out(hit_xy_out),
        .hit_z_out(hit_z_out), .color_out(color_out)
`ifdef SAMPLETEST_HIT_STATS_EN
        , .hit_cnt_out(hit_cnt_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [LANES-1:0]  mask;
        logic [SW-1:0]     xy;
        logic [SIGFIG-1:0] z;
        logic [CW-1:0]     color;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out    = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: edge functions evaluated in wide integers on the sample-relative triangle.
    function automatic logic [LANES-1:0] model_mask();
        longint px [3];
        longint py [3];
        longint d  [3];
        bit     front, back;
        logic [LANES-1:0] m = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int v = 0; v < 3; v++) begin
                px[v] = longint'($signed(tri_in[(v*AXIS)*SIGFIG +: SIGFIG]))
                      - longint'($signed(sample_in[(l*2)*SIGFIG +: SIGFIG]));
                py[v] = longint'($signed(tri_in[(v*AXIS+1)*SIGFIG +: SIGFIG]))
                      - longint'($signed(sample_in[(l*2+1)*SIGFIG +: SIGFIG]));
            end
            for (int e = 0; e < 3; e++)
                d[e] = px[e] * py[(e+1)%3] - px[(e+1)%3] * py[e];
            front = d[0] <= 0 && d[1] < 0 && d[2] <= 0;
            back  = d[0] >= 0 && d[1] > 0 && d[2] >= 0;
            m[l]  = lane_en_in[l] && (front || (!cull_back_in && back));
        end
        return m;
    endfunction

    task automatic set_vert(input int v, input int x, input int y, input int z);
        tri_in[(v*AXIS)*SIGFIG +: SIGFIG]   = SIGFIG'(x);
        tri_in[(v*AXIS+1)*SIGFIG +: SIGFIG] = SIGFIG'(y);
        tri_in[(v*AXIS+2)*SIGFIG +: SIGFIG] = SIGFIG'(z);
    endtask

    task automatic set_lane(input int l, input int x, input int y);
        sample_in[(l*2)*SIGFIG +: SIGFIG]   = SIGFIG'(x);
        sample_in[(l*2+1)*SIGFIG +: SIGFIG] = SIGFIG'(y);
    endtask

    function automatic int rnd();
        return int'($urandom_range(0, 8191)) - 4096;
    endfunction

    task automatic rand_pkt();
        int x0, y0;
        for (int v = 0; v < 3; v++) set_vert(v, rnd(), rnd(), int'($urandom_range(0, 65535)));
        if ($urandom_range(0, 15) == 0) begin
            x0 = rnd(); y0 = rnd();
            for (int v = 0; v < 3; v++) set_vert(v, x0, y0, 123);
        end
        for (int l = 0; l < LANES; l++) set_lane(l, rnd(), rnd());
        color_in     = CW'({$urandom, $urandom, $urandom});
        lane_en_in   = LANES'($urandom);
        cull_back_in = 1'($urandom);
    endtask

    task automatic tri_front();
        set_vert(0, -1024, -1024, 77);
        set_vert(1, 0, 1024, 5);
        set_vert(2, 1024, -1024, 9);
        color_in = CW'(72'h123456_abcdef_0f0f0f);
    endtask

    task automatic tri_back();
        set_vert(0, -1024, -1024, 88);
        set_vert(1, 1024, -1024, 5);
        set_vert(2, 0, 1024, 9);
        color_in = CW'(72'h654321_fedcba_f0f0f0);
    endtask

    // One clock: score the handshakes about to happen, then advance past the edge.
    task automatic cycle(output bit acc);
        #1;
        acc = in_valid && in_ready;
        check("in_ready", in_ready, !(out_valid && !out_ready));
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out", 1'b1, 1'b0);
            end else begin
                check("mask", hit_mask_out, sb[0].mask);
                check("xy", hit_xy_out, sb[0].xy);
                check("z", hit_z_out, sb[0].z);
                check("color", color_out, sb[0].color);
            end
            if (out_ready) begin
`ifdef SAMPLETEST_HIT_STATS_EN
                exp_cnt = exp_cnt + $countones(hit_mask_out);
                if (exp_cnt > 64'hFFFF_FFFF) exp_cnt = 64'hFFFF_FFFF;
`endif
                if (sb.size() != 0) void'(sb.pop_front());
                n_out++;
            end
        end
        if (acc) sb.push_back('{model_mask(), sample_in, tri_in[2*SIGFIG +: SIGFIG], color_in});
        @(posedge clk);
        #1;
`ifdef SAMPLETEST_HIT_STATS_EN
        check("hit_cnt", hit_cnt_out, 32'(exp_cnt));
`endif
    endtask

    task automatic run_single(input string tag, input logic [LANES-1:0] want);
        bit acc;
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        cycle(acc);
        check({tag, "_acc"}, acc, 1'b1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            cycle(acc);
            lat++;
        end
        check({tag, "_lat"}, lat, PIPE_DEPTH);
        check({tag, "_mask"}, hit_mask_out, want);
        cycle(acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit acc;
        bit need_new;
        int p, it, n0;
        logic [LANES-1:0] en_tab [3];
        en_tab[0] = 4'b1011; en_tab[1] = 4'b0000; en_tab[2] = 4'b1111;
`ifdef SAMPLETEST_HIT_STATS_EN
        exp_cnt = 0;
`endif
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tri_in = '0; color_in = '0; sample_in = '0; lane_en_in = '0; cull_back_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_mask", hit_mask_out, '0);
        check("rst_xy", hit_xy_out, '0);
        check("rst_z", hit_z_out, '0);
        check("rst_color", color_out, '0);
`ifdef SAMPLETEST_HIT_STATS_EN
        check("rst_cnt", hit_cnt_out, '0);
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // Directed geometry
        tri_front();
        set_lane(0, 0, 0); set_lane(1, 2048, 0); set_lane(2, 0, 0); set_lane(3, -2048, 0);
        lane_en_in = 4'b1111; cull_back_in = 1'b1;
        run_single("front", 4'b0101);
        tri_back();
        run_single("back_cull", 4'b0000);
        cull_back_in = 1'b0;
        run_single("back_nocull", 4'b0101);
        tri_front(); cull_back_in = 1'b1;
        set_lane(0, 512, 0); set_lane(1, -512, 0); set_lane(2, 0, -1024); set_lane(3, 0, 0);
        run_single("edges", 4'b1110);
        lane_en_in = 4'b0000;
        run_single("lanes_off", 4'b0000);
        lane_en_in = 4'b0001; set_lane(0, 0, 0);
        run_single("one_lane", 4'b0001);
        for (int v = 0; v < 3; v++) set_vert(v, 100, 100, 3);
        lane_en_in = 4'b1111; cull_back_in = 1'b0;
        for (int l = 0; l < LANES; l++) set_lane(l, 100, 100);
        run_single("degenerate", 4'b0000);

        // 8 back-to-back packets with a 3-cycle downstream stall
        n0 = n_out; p = 0; it = 0; need_new = 1'b1;
        while ((p < 8 || sb.size() != 0) && it < 100) begin
            out_ready = !(it >= 4 && it < 7);
            if (p < 8) begin
                if (need_new) rand_pkt();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            cycle(acc);
            if (acc) p++;
            need_new = acc;
            it++;
        end
        check("stall_count", n_out - n0, 8);
        check("stall_empty", sb.size(), 0);

        // Asynchronous reset with packets in flight
        tri_front(); lane_en_in = 4'b1111; cull_back_in = 1'b1;
        for (int l = 0; l < LANES; l++) set_lane(l, 0, 0);
        out_ready = 1'b1; in_valid = 1'b1;
        cycle(acc);
        cycle(acc);
        in_valid = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_mask", hit_mask_out, '0);
`ifdef SAMPLETEST_HIT_STATS_EN
        check("arst_cnt", hit_cnt_out, '0);
        exp_cnt = 0;
`endif
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle(acc);
            check("post_rst_valid", out_valid, 1'b0);
        end

`ifdef SAMPLETEST_HIT_STATS_EN
        // Three transfers with 3 + 0 + 4 hits, including a held output
        for (int k = 0; k < 3; k++) begin
            lane_en_in = en_tab[k];
            in_valid   = 1'b1;
            cycle(acc);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) cycle(acc);
        out_ready = 1'b1;
        repeat (PIPE_DEPTH + 3) cycle(acc);
        check("stats_total", hit_cnt_out, 32'd7);
`endif

        // Randomized traffic with random back-pressure
        for (int k = 0; k < 400; k++) begin
            rand_pkt();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle(acc);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        it = 0;
        while (sb.size() != 0 && it < 20) begin
            cycle(acc);
            it++;
        end
        check("drain_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sampletest_multi.md
# sampletest_multi

Parametrised successor to the single-sample sample test. Each cycle it accepts one triangle plus a packet of `LANES` sample locations and tests every lane against the triangle's three edge equations in parallel. It produces a per-lane hit mask, with optional back-face culling selected at run time, through a stallable valid/ready pipeline of configurable depth. It sits between the sample iterator and the z-buffer/hash stage.

## Interface
- `SIGFIG`, 24, bits in color and position (signed fixed point)
- `RADIX`, 10, fraction bits in position
- `AXIS`, 3, axes per vertex (x,y,z)
- `COLORS`, 3, color channels
- `LANES`, 4, samples tested per packet (1..16)
- `PIPE_DEPTH`, 2, pipeline stages from input handshake to output valid (>=1)

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low; assertion clears state immediately, deassertion is synchronised externally
- `in_valid`  in  1  packet valid
- `in_ready`  out  1  block can accept a packet
- `tri_in`  in  3x`AXIS`x`SIGFIG`  triangle vertices, signed
- `color_in`  in  `COLORS`x`SIGFIG`  triangle color, unsigned
- `sample_in`  in  `LANES`x2x`SIGFIG`  sample (x,y) per lane, signed
- `lane_en_in`  in  `LANES`  per-lane sample-valid
- `cull_back_in`  in  1  1 = reject back-facing triangles
- `out_valid`  out  1  output packet valid
- `out_ready`  in  1  downstream accepts
- `hit_mask_out`  out  `LANES`  per-lane hit
- `hit_xy_out`  out  `LANES`x2x`SIGFIG`  unjittered sample positions
- `hit_z_out`  out  `SIGFIG`  z of vertex 0
- `color_out`  out  `COLORS`x`SIGFIG`  color passthrough
- `hit_cnt_out`  out  32  present only with the config macro

## Operation
- Per lane: shift the vertices by the sample (`v - s`). Edges are e0=(v0,v1), e1=(v1,v2), e2=(v2,v0).
- Edge distance is `d = xa*yb - xb*ya`. Products are 2*`SIGFIG` bits. The difference is sign-extended to 2*`SIGFIG`+1 bits, so no overflow is possible.
- Front-facing hit: `d0<=0 && d1<0 && d2<=0`. The strict inequality on e1 is the tie-break.
- Back-facing hit: `d0>=0 && d1>0 && d2>=0`. It counts only when `cull_back_in`=0.
- `hit_mask[i] = lane_en[i] && (front_hit || (!cull && back_hit))`.
- Degenerate triangle (all d=0) never hits.
- Stage 1 registers the shifted vertices. Multiply/compare is spread over the remaining stages; retiming is permitted.
- Stall is global: `stall = out_valid && !out_ready`; `in_ready = !stall`. While stalled, every stage holds.
- A packet with `lane_en_in`=0 still flows and emits an all-zero mask.
- All non-mask data is passthrough, delayed in lockstep with the mask.

## Timing
- Latency: an accepted packet appears on the outputs exactly `PIPE_DEPTH` cycles later, absent stall.
- Throughput: 1 packet/cycle.
- An input transfer occurs on a `clk` edge with `in_valid && in_ready`. An output transfer occurs with `out_valid && out_ready`.
- Outputs are stable while `out_valid && !out_ready`.
- Reset values: `out_valid`=0 and `hit_mask_out`=0. `hit_xy_out`, `hit_z_out` and `color_out` reset to 0. `in_ready`=1 one cycle after reset, since it follows from `out_valid`=0. `hit_cnt_out`=0.
- Reset mid-operation: all in-flight packets are dropped, and no `out_valid` is produced for them.
- Bubbles (`in_valid`=0) propagate as invalid stages and do not collapse while stalled.
- A bubble in a stage does not block acceptance when the output is empty.

## Configuration
- `SAMPLETEST_HIT_STATS_EN`: when defined, `hit_cnt_out` accumulates popcount(`hit_mask_out`) on each output transfer. It is 32-bit, saturates at 0xFFFFFFFF and is cleared by `rst`.
- When undefined, the port and counter are absent and the block has no additional logic.

## Test plan
- Front-facing triangle v0=(-1024,-1024), v1=(0,1024), v2=(1024,-1024), lane0=(0,0), lane1=(2048,0), all lanes enabled, `cull_back_in`=1 -> after `PIPE_DEPTH` cycles, mask bit0=1, bit1=0.
- Same triangle with v1/v2 swapped (back-facing), lane0=(0,0): `cull_back_in`=1 -> bit0=0; `cull_back_in`=0 -> bit0=1.
- Sample on e1 (lane=(512,0) with v1=(0,1024), v2=(1024,-1024); d1=0) -> miss. Sample on e0/e2 boundaries (d=0, others negative) -> hit.
- Back-to-back 8 packets with `out_ready` low for 3 cycles mid-stream -> outputs held, `in_ready`=0 during stall, all 8 packets emerge in order with none lost or duplicated.
- `rst` asserted asynchronously with 2 packets in flight -> `out_valid`=0 immediately, no stale packet after release. With `SAMPLETEST_HIT_STATS_EN`, `hit_cnt_out`=0.
- Stats build: 3 transfers with masks 4'b1011, 4'b0000, 4'b1111 -> `hit_cnt_out`=7. A held (stalled) output is not double-counted.
